// File: rtl/fault_inject_pkg.sv
// Shared state encoding and default widths for the fault injection controller.
// The optional periodic mode is enabled by defining FAULT_INJ_PERIODIC_EN.
package fault_inject_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        INJECT = 2'd2,
        DONE   = 2'd3
    } fi_state_t;

    localparam int DEF_DATA_W    = 34;
    localparam int DEF_FIELD_LSB = 28;
    localparam int DEF_FIELD_W   = 4;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/fault_field_mux.sv
// Combinational field corruptor: overwrites or XORs one header field of a word.
// Every bit outside the field passes through untouched.
module fault_field_mux #(
    parameter int DATA_W    = 34,
    parameter int FIELD_LSB = 28,
    parameter int FIELD_W   = 4
) (
    input  logic [DATA_W-1:0]  word,
    input  logic [FIELD_W-1:0] value,
    input  logic               xorMode,
    input  logic               enable,
    output logic [DATA_W-1:0]  result
);

    for (genvar gi = 0; gi < DATA_W; gi++) begin : gBit
        if (gi >= FIELD_LSB && gi < FIELD_LSB + FIELD_W) begin : gField
            logic valueBit;
            assign valueBit   = value[gi-FIELD_LSB];
            assign result[gi] = enable ? (xorMode ? (word[gi] ^ valueBit) : valueBit)
                                       : word[gi];
        end else begin : gPass
            assign result[gi] = word[gi];
        end
    end

endmodule

// File: rtl/fault_inject_ctrl.sv
// In-line fault injector: passes a word stream with one cycle of latency and corrupts
// a burst of words after a programmable delay. Define FAULT_INJ_PERIODIC_EN for repeated bursts.
module fault_inject_ctrl
    import fault_inject_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FIELD_LSB = DEF_FIELD_LSB,
    parameter int FIELD_W   = DEF_FIELD_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic [CNT_W-1:0]   cfg_delay,
    input  logic [CNT_W-1:0]   cfg_burst,
    input  logic [FIELD_W-1:0] cfg_value,
    input  logic               cfg_xor,
`ifdef FAULT_INJ_PERIODIC_EN
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_reps,
`endif
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_faulted,
    output logic               busy,
    output logic [CNT_W-1:0]   fault_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fi_state_t          stateReg, stateNext;
    logic [CNT_W-1:0]   delayCntReg, delayCntNext;
    logic [CNT_W-1:0]   burstCntReg, burstCntNext;
    logic [CNT_W-1:0]   faultCntReg;
    logic [FIELD_W-1:0] valueReg;
    logic               xorReg;
    logic               armAccept;
    logic               corrupt;
    logic [DATA_W-1:0]  muxedWord;
    logic [DATA_W-1:0]  outDataReg;
    logic               outValidReg;
    logic               outFaultedReg;
`ifdef FAULT_INJ_PERIODIC_EN
    logic [CNT_W-1:0]   periodReg;
    logic [CNT_W-1:0]   repsReg;
    logic [CNT_W-1:0]   burstLoadReg;
    logic [CNT_W-1:0]   repsCntReg, repsCntNext;
`endif

    assign armAccept = (stateReg == IDLE) && arm && !abort;

    always_comb begin
        stateNext    = stateReg;
        delayCntNext = delayCntReg;
        burstCntNext = burstCntReg;
        corrupt      = 1'b0;
`ifdef FAULT_INJ_PERIODIC_EN
        repsCntNext  = repsCntReg;
`endif
        if (abort) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (arm) begin
                        delayCntNext = cfg_delay;
                        burstCntNext = cfg_burst;
                        stateNext    = (cfg_burst == '0) ? DONE : ARMED;
`ifdef FAULT_INJ_PERIODIC_EN
                        repsCntNext  = '0;
`endif
                    end
                end
                ARMED: begin
                    if (in_valid) begin
                        if (delayCntReg == '0) corrupt = 1'b1;
                        else                   delayCntNext = delayCntReg - CNT_ONE;
                    end
                end
                INJECT:  corrupt   = in_valid;
                default: stateNext = IDLE;
            endcase
        end

        // Shared burst bookkeeping for the first and subsequent corrupted words.
        if (corrupt) begin
            burstCntNext = burstCntReg - CNT_ONE;
            if (burstCntReg == CNT_ONE) begin
`ifdef FAULT_INJ_PERIODIC_EN
                repsCntNext = repsCntReg + CNT_ONE;
                if (repsReg != '0 && repsCntNext == repsReg) begin
                    stateNext = DONE;
                end else begin
                    stateNext    = ARMED;
                    delayCntNext = periodReg;
                    burstCntNext = burstLoadReg;
                end
`else
                stateNext = DONE;
`endif
            end else begin
                stateNext = INJECT;
            end
        end
    end

    fault_field_mux #(
        .DATA_W    (DATA_W),
        .FIELD_LSB (FIELD_LSB),
        .FIELD_W   (FIELD_W)
    ) uFieldMux (
        .word    (in_data),
        .value   (valueReg),
        .xorMode (xorReg),
        .enable  (corrupt),
        .result  (muxedWord)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg      <= IDLE;
            delayCntReg   <= '0;
            burstCntReg   <= '0;
            faultCntReg   <= '0;
            valueReg      <= '0;
            xorReg        <= 1'b0;
            outDataReg    <= '0;
            outValidReg   <= 1'b0;
            outFaultedReg <= 1'b0;
`ifdef FAULT_INJ_PERIODIC_EN
            periodReg     <= '0;
            repsReg       <= '0;
            burstLoadReg  <= '0;
            repsCntReg    <= '0;
`endif
        end else begin
            stateReg      <= stateNext;
            delayCntReg   <= delayCntNext;
            burstCntReg   <= burstCntNext;
            outDataReg    <= muxedWord;
            outValidReg   <= in_valid;
            outFaultedReg <= corrupt;
            if (corrupt && faultCntReg != '1) faultCntReg <= faultCntReg + CNT_ONE;
            if (armAccept) begin
                valueReg <= cfg_value;
                xorReg   <= cfg_xor;
            end
`ifdef FAULT_INJ_PERIODIC_EN
            repsCntReg <= repsCntNext;
            if (armAccept) begin
                periodReg    <= cfg_period;
                repsReg      <= cfg_reps;
                burstLoadReg <= cfg_burst;
            end
`endif
        end
    end

    assign out_data    = outDataReg;
    assign out_valid   = outValidReg;
    assign out_faulted = outFaultedReg;
    assign busy        = (stateReg == ARMED) || (stateReg == INJECT);
    assign fault_cnt   = faultCntReg;

endmodule

// File: doc/fault_inject_ctrl.md
FAULT_INJECT_CTRL -- requirements
Module: fault_inject_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 34, meaning the width of the flit/word passing through.
REQ-002 SHALL have parameter FIELD_LSB, default 28, meaning the LSB of the header field to corrupt.
REQ-003 SHALL have parameter FIELD_W, default 4, meaning the width of the corrupted field.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the width of the delay, burst and statistics counters.
REQ-005 SHALL have a single clock input, clk, 1 bit, with all logic on its rising edge.
REQ-006 SHALL have input rst_n, 1 bit, as a synchronous active-low reset.
REQ-007 SHALL have input arm, 1 bit, as a one-cycle pulse that starts a campaign.
REQ-008 SHALL have input abort, 1 bit, as a one-cycle pulse that returns to IDLE.
REQ-009 SHALL have input cfg_delay, CNT_W bits, giving the number of valid words passed clean before injection.
REQ-010 SHALL have input cfg_burst, CNT_W bits, giving the number of valid words corrupted per burst.
REQ-011 SHALL have input cfg_value, FIELD_W bits, giving the value written into the field.
REQ-012 SHALL have input cfg_xor, 1 bit: 0 means the field is overwritten with cfg_value; 1 means the field is XORed with cfg_value.
REQ-013 SHALL have input in_data, DATA_W bits, as the upstream word, and input in_valid, 1 bit, as the upstream qualifier.
REQ-014 SHALL have output out_data, DATA_W bits, as the possibly corrupted word, and output out_valid, 1 bit, as its qualifier.
REQ-015 SHALL have output out_faulted, 1 bit, set high when the current out_data word was corrupted.
REQ-016 SHALL have output busy, 1 bit, high in ARMED or INJECT.
REQ-017 SHALL have output fault_cnt, CNT_W bits, holding the total number of corrupted words.

Function
REQ-018 SHALL register the datapath with exactly 1 cycle latency: out_valid/out_data/out_faulted at cycle N+1 reflect in_valid/in_data at N.
REQ-019 SHALL implement a four-state FSM with states IDLE, ARMED, INJECT and DONE.
REQ-020 SHALL transition IDLE->ARMED on arm, loading the delay counter with cfg_delay and the burst counter with cfg_burst; cfg_* is sampled only at this point.
REQ-021 SHALL in ARMED decrement the delay counter per in_valid word, passing words clean; at 0 with in_valid, that word is the first corrupted one and the FSM enters INJECT.
REQ-022 SHALL, with cfg_delay=0, corrupt the first valid word after arm, and SHALL NOT corrupt a word on the arm cycle itself.
REQ-023 SHALL in INJECT corrupt each valid word, decrementing the burst counter; after the last corrupted word it goes to DONE (or ARMED when periodic, REQ-033).
REQ-024 SHALL go directly to DONE on arm with cfg_burst=0, corrupting nothing.
REQ-025 SHALL apply corruption only to bits [FIELD_LSB+FIELD_W-1:FIELD_LSB]; all other bits pass unchanged.
REQ-026 SHALL hold state and counters on idle cycles (in_valid=0), and words with in_valid=0 never count or fault.
REQ-027 SHALL return to IDLE from DONE on the next cycle and SHALL ignore arm while busy.
REQ-028 SHALL give abort priority over arm and over the pending word: the word on the abort cycle passes clean and the FSM enters IDLE.
REQ-029 SHALL increment fault_cnt by 1 per corrupted word, saturating at all-ones; it is cleared only by reset.

Reset
REQ-030 SHALL on rst_n=0 at a clock edge set state to IDLE, all counters and fault_cnt to 0, and out_valid, out_faulted, out_data and busy to 0.
REQ-031 SHALL on a mid-burst reset drop the burst with no further corruption.

Configuration
REQ-032 SHALL gate the periodic behaviour with macro FAULT_INJ_PERIODIC_EN, which adds input cfg_period (CNT_W) and input cfg_reps (CNT_W, 0 meaning infinite).
REQ-033 SHALL with FAULT_INJ_PERIODIC_EN defined, after each burst, reload the delay counter with cfg_period and return to ARMED until cfg_reps bursts are done, then go to DONE.
REQ-034 SHALL without FAULT_INJ_PERIODIC_EN, omit those ports and perform one burst per arm.

Structure
REQ-035 SHALL place state encoding (fi_state_t, 2-bit) and default widths in package fault_inject_pkg.
REQ-036 SHALL place field corruption (overwrite/XOR of the field) in combinational sub-module fault_field_mux, which the register stage instantiates.

Verification
REQ-037 SHALL verify: cfg_delay=2, cfg_burst=3, cfg_value=4'b0010, overwrite mode, 6 consecutive valid words -> words 0-1 clean, words 2-4 have bits[31:28]=0010 and out_faulted=1, word 5 clean, fault_cnt=3, one idle cycle in DONE, then IDLE.
REQ-038 SHALL verify: XOR mode, cfg_value=4'hF, in_data field=4'hA -> out field=4'h5, other 30 bits identical.
REQ-039 SHALL verify: in_valid gaps of 3 cycles between words -> same corrupted word indices as contiguous, counters frozen during gaps.
REQ-040 SHALL verify: abort during the 2nd burst word -> that word clean, busy=0 the next cycle, fault_cnt=1.
REQ-041 SHALL verify: cfg_burst=0 -> no word corrupted, DONE reached; arm pulsed while busy -> ignored.
REQ-042 SHALL verify: with FAULT_INJ_PERIODIC_EN, cfg_period=1, cfg_burst=1, cfg_reps=3 -> faulted, clean, faulted, clean, faulted, then DONE, fault_cnt=3.
